spi_arbiter: RTL and testbench

Round-robin transaction controller that shares one `spi_core` instance (CPOL=0, CPHA=1) between `NREQ` requesters. Each requester presents a stream of `DWIDTH`-bit words framed by a `last` flag. The arbiter grants the bus per transaction, drives that requester's active-low slave select and feeds words to the core one at a time. It returns each received word to the granted requester. It sits between the client blocks and `spi_core`, and is the only block allowed to drive the core's `cs`/`wr`/`din`.

---
 rtl/spi_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_spi_arbiter.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_arbiter                                                  |
// | Description : Round-robin transaction controller sharing one spi_core      |
// |               between NREQ requesters. Grants per transaction, drives the  |
// |               owner's slave select, issues one word at a time to the core  |
// |               and returns each received word to the owner.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_arbiter #(
   parameter int DWIDTH   = 8,
   parameter int NREQ     = 2,
   parameter int SS_SETUP = 2,
   parameter int SS_GAP   = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ-1:0]          req_last,
   input  logic [NREQ*DWIDTH-1:0]   req_data,
   output logic [NREQ-1:0]          req_ready,
   output logic [DWIDTH-1:0]        rsp_data,
   output logic [NREQ-1:0]          rsp_valid,
   output logic [NREQ-1:0]          grant,
   output logic                     busy,
   output logic [NREQ-1:0]          ss_n,
   output logic                     core_cs,
   output logic                     core_wr,
   output logic                     core_rd,
   output logic [DWIDTH-1:0]        core_din,
   input  logic [DWIDTH-1:0]        core_dout,
   input  logic                     core_done
);

   localparam int              c_IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [c_IW:0]   c_NREQ  = (c_IW+1)'(NREQ);
   localparam logic [3:0]      c_SETUP = 4'(SS_SETUP);
   localparam logic [3:0]      c_GAP   = 4'(SS_GAP);
   localparam logic [NREQ-1:0] c_ONE   = NREQ'(1);

   localparam logic [2:0] c_IDLE      = 3'd0;
   localparam logic [2:0] c_SETUP_ST  = 3'd1;
   localparam logic [2:0] c_ISSUE     = 3'd2;
   localparam logic [2:0] c_WAIT_BUSY = 3'd3;
   localparam logic [2:0] c_WAIT_DONE = 3'd4;
   localparam logic [2:0] c_GAP_ST    = 3'd5;

   logic [2:0]        r_state;
   logic [2:0]        w_state_nxt;
   logic [c_IW-1:0]   r_ptr;
   logic [c_IW-1:0]   r_g;
   logic [3:0]        r_cnt;
   logic              r_last;
   logic [NREQ-1:0]   r_grant;
   logic [NREQ-1:0]   r_ss_n;
   logic              r_core_wr;
   logic [DWIDTH-1:0] r_core_din;
   logic [DWIDTH-1:0] r_rsp_data;
   logic [NREQ-1:0]   r_rsp_valid;

   logic [c_IW:0]     w_sum;
   logic [c_IW-1:0]   w_idx;
   logic [c_IW-1:0]   w_pick;
   logic              w_found;
   logic [c_IW:0]     w_ptr_sum;
   logic [c_IW-1:0]   w_ptr_nxt;
   logic [3:0]        w_cnt_dec;
   logic [NREQ-1:0]   w_g_oh;
   logic [NREQ-1:0]   w_pick_oh;
   logic [DWIDTH-1:0] w_word;
   logic              w_hs;

   // The counter saturates at zero; SETUP and GAP exit once the decremented value reaches zero,
   // so ss_n leads the first word by SS_SETUP clocks and the idle gap spans SS_GAP+1 clocks.
   assign w_cnt_dec = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
   assign w_g_oh    = c_ONE << r_g;
   assign w_pick_oh = c_ONE << w_pick;
   assign w_word    = req_data[r_g*DWIDTH +: DWIDTH];
   assign w_hs      = (r_state == c_ISSUE) && req_valid[r_g];

   // Round-robin search: first valid requester at or above the pointer, wrapping.
   always_comb begin
      w_found   = 1'b0;
      w_pick    = '0;
      w_sum     = '0;
      w_idx     = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_sum = {1'b0, r_ptr} + (c_IW+1)'(i);
         if (w_sum >= c_NREQ) w_sum = w_sum - c_NREQ;
         w_idx = w_sum[c_IW-1:0];
         if (!w_found && req_valid[w_idx]) begin
            w_found = 1'b1;
            w_pick  = w_idx;
         end
      end
      w_ptr_sum = {1'b0, w_pick} + (c_IW+1)'(1);
      w_ptr_nxt = (w_ptr_sum >= c_NREQ) ? '0 : w_ptr_sum[c_IW-1:0];
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= c_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:      if (w_found)                            w_state_nxt = c_SETUP_ST;
         c_SETUP_ST:  if ((w_cnt_dec == 4'd0) && core_done)   w_state_nxt = c_ISSUE;
         c_ISSUE:     if (w_hs)                               w_state_nxt = c_WAIT_BUSY;
         c_WAIT_BUSY: if (!core_done)                         w_state_nxt = c_WAIT_DONE;
         c_WAIT_DONE: if (core_done)                          w_state_nxt = r_last ? c_GAP_ST : c_ISSUE;
         c_GAP_ST:    if (w_cnt_dec == 4'd0)                  w_state_nxt = c_IDLE;
         default:                                             w_state_nxt = c_IDLE;
      endcase
   end

   // Registered datapath: grant/select, counter, core write strobe and response capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr       <= '0;
         r_g         <= '0;
         r_cnt       <= '0;
         r_last      <= 1'b0;
         r_grant     <= '0;
         r_ss_n      <= '1;
         r_core_wr   <= 1'b0;
         r_core_din  <= '0;
         r_rsp_data  <= '0;
         r_rsp_valid <= '0;
      end else begin
         r_core_wr   <= 1'b0;
         r_rsp_valid <= '0;
         case (r_state)
            c_IDLE: begin
               if (w_found) begin
                  r_g     <= w_pick;
                  r_grant <= w_pick_oh;
                  r_ss_n  <= ~w_pick_oh;
                  r_cnt   <= c_SETUP;
                  r_ptr   <= w_ptr_nxt;
               end
            end
            c_SETUP_ST: r_cnt <= w_cnt_dec;
            c_ISSUE: begin
               if (w_hs) begin
                  r_core_din <= w_word;
                  r_core_wr  <= 1'b1;
                  r_last     <= req_last[r_g];
               end
            end
            c_WAIT_DONE: begin
               if (core_done) begin
                  r_rsp_data  <= core_dout;
                  r_rsp_valid <= w_g_oh;
                  if (r_last) begin
                     r_ss_n  <= '1;
                     r_grant <= '0;
                     r_cnt   <= c_GAP;
                  end
               end
            end
            c_GAP_ST: r_cnt <= w_cnt_dec;
            default: ;
         endcase
      end
   end

   // Combinational outputs decoded from the current state.
   always_comb begin
      req_ready = '0;
      if (r_state == c_ISSUE) req_ready = req_valid & w_g_oh;
      busy = (r_state != c_IDLE);
   end

   assign grant     = r_grant;
   assign ss_n      = r_ss_n;
   assign core_cs   = r_core_wr;
   assign core_wr   = r_core_wr;
   assign core_rd   = 1'b0;
   assign core_din  = r_core_din;
   assign rsp_data  = r_rsp_data;
   assign rsp_valid = r_rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_spi_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_spi_arbiter                                               |
// | Description : Self-checking bench for spi_arbiter with a behavioural       |
// |               spi_core model, per-requester word queues and a scoreboard.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_spi_arbiter;
   localparam int DW    = 8;
   localparam int NR    = 2;
   localparam int SETUP = 2;
   localparam int GAP   = 3;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
      int            pre;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NR-1:0]    req_valid = '0, req_last = '0;
   logic [NR*DW-1:0] req_data = '0;
   logic [NR-1:0]    req_ready, rsp_valid, grant, ss_n;
   logic [DW-1:0]    rsp_data, core_din;
   logic [DW-1:0]    core_dout = '0;
   logic             busy, core_cs, core_wr, core_rd;
   logic             core_done = 1'b1;

   int vectors = 0, miscompares = 0;
   ent_t          txq [NR][$];
   logic [DW-1:0] expq [NR][$];
   logic [DW-1:0] key = '0;
   int            core_lat = 5;
   logic          in_rst = 1'b1;
   int            hs_seq = 0;
   logic [DW-1:0] hs_word = '0;
   int            rsp_total = 0;

   spi_arbiter #(.DWIDTH(DW), .NREQ(NR), .SS_SETUP(SETUP), .SS_GAP(GAP)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
      .req_ready(req_ready), .rsp_data(rsp_data), .rsp_valid(rsp_valid), .grant(grant),
      .busy(busy), .ss_n(ss_n), .core_cs(core_cs), .core_wr(core_wr), .core_rd(core_rd),
      .core_din(core_din), .core_dout(core_dout), .core_done(core_done));

   always #5 clk = ~clk;

   // Behavioural spi_core: takes a word on wr, is busy for a while, returns word ^ key.
   int            core_cnt = 0;
   logic [DW-1:0] core_word = '0;
   always @(posedge clk) begin
      if (core_wr) begin
         core_done <= 1'b0;
         core_cnt  <= core_lat + int'($urandom_range(0, 3));
         core_word <= core_din;
      end else if (!core_done) begin
         if (core_cnt == 0) begin
            core_done <= 1'b1;
            core_dout <= core_word ^ key;
         end else core_cnt <= core_cnt - 1;
      end
   end

   // Requester driver: presents queue heads (after their pre-delay) and pops on handshake.
   initial begin
      ent_t e;
      forever begin
         @(negedge clk);
         for (int r = 0; r < NR; r++) begin
            req_valid[r] = 1'b0;
            if (txq[r].size() > 0) begin
               e = txq[r][0];
               if (e.pre > 0) begin
                  e.pre = e.pre - 1;
                  txq[r][0] = e;
               end else begin
                  req_valid[r] = 1'b1;
                  req_last[r]  = e.last;
                  req_data[r*DW +: DW] = e.data;
               end
            end
         end
         #1;
         for (int r = 0; r < NR; r++) begin
            if (req_valid[r] && req_ready[r]) begin
               e = txq[r].pop_front();
               hs_word = e.data;
               hs_seq  = hs_seq + 1;
            end
         end
      end
   end

   // Monitor: protocol invariants, round-robin grant model and response scoreboard.
   initial begin
      int            mon_seq, last_g, idx;
      logic          exp_wr;
      logic [DW-1:0] exp_word, got;
      logic [NR-1:0] prev_grant, prev_valid, exp_oh;
      mon_seq = 0; last_g = NR - 1; exp_wr = 1'b0; exp_word = '0;
      prev_grant = '0; prev_valid = '0;
      forever begin
         @(negedge clk);
         #2;
         if (in_rst) begin
            exp_wr = 1'b0; mon_seq = hs_seq; prev_grant = '0; prev_valid = req_valid;
            last_g = NR - 1;
            for (int r = 0; r < NR; r++) expq[r].delete();
            continue;
         end
         vectors++;
         if (core_wr !== exp_wr) begin
            miscompares++; $display("FAIL core_wr_pulse: got %b expected %b at %0t", core_wr, exp_wr, $time);
         end
         if (exp_wr) begin
            vectors++;
            if (core_din !== exp_word) begin
               miscompares++; $display("FAIL core_din: got %h expected %h", core_din, exp_word);
            end
         end
         vectors++;
         if (core_cs !== core_wr || core_rd !== 1'b0) begin
            miscompares++; $display("FAIL core_cs_rd: got cs=%b rd=%b expected cs=%b rd=0", core_cs, core_rd, core_wr);
         end
         vectors++;
         if (ss_n !== ~grant || !$onehot0(grant)) begin
            miscompares++; $display("FAIL ss_n_vs_grant: got ss_n=%b grant=%b expected ss_n=~grant, one-hot", ss_n, grant);
         end
         if (prev_grant != '0 && grant != '0) begin
            vectors++;
            if (grant !== prev_grant) begin
               miscompares++; $display("FAIL preempt: got grant %b expected %b", grant, prev_grant);
            end
         end
         if (prev_grant == '0 && grant != '0) begin
            idx = -1;
            for (int k = 1; k <= NR; k++)
               if (idx < 0 && prev_valid[(last_g + k) % NR]) idx = (last_g + k) % NR;
            exp_oh = (idx < 0) ? '0 : NR'(1 << idx);
            vectors++;
            if (grant !== exp_oh) begin
               miscompares++; $display("FAIL rr_grant: got %b expected %b", grant, exp_oh);
            end
            if (idx >= 0) last_g = idx;
         end
         if (rsp_valid != '0) begin
            rsp_total++;
            vectors++;
            if (!$onehot(rsp_valid) || rsp_valid !== prev_grant) begin
               miscompares++; $display("FAIL rsp_valid_owner: got %b expected %b", rsp_valid, prev_grant);
            end else begin
               idx = $clog2(rsp_valid);
               vectors++;
               if (expq[idx].size() == 0) begin
                  miscompares++; $display("FAIL rsp_unexpected: got %h expected none for req %0d", rsp_data, idx);
               end else begin
                  got = expq[idx].pop_front();
                  if (rsp_data !== got) begin
                     miscompares++; $display("FAIL rsp_data: got %h expected %h (req %0d)", rsp_data, got, idx);
                  end
               end
            end
         end
         exp_wr = 1'b0;
         if (hs_seq != mon_seq) begin
            mon_seq  = hs_seq;
            exp_wr   = 1'b1;
            exp_word = hs_word;
            for (int r = 0; r < NR; r++)
               if (req_valid[r] && req_ready[r]) expq[r].push_back(hs_word ^ key);
         end
         prev_grant = grant;
         prev_valid = req_valid;
      end
   end

   task automatic tick();
      @(negedge clk);
      #3;
   endtask

   task automatic wait_idle(input int bound, input string name);
      logic ok;
      ok = 1'b0;
      for (int k = 0; k < bound; k++) begin
         tick();
         if (txq[0].size() == 0 && txq[1].size() == 0 && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      vectors++;
      if (!ok) begin
         miscompares++; $display("FAIL %s_idle_timeout: got busy=%b expected idle within %0d cycles", name, busy, bound);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) tick();
      vectors++;
      if (ss_n !== 2'b11 || grant !== 2'b00 || busy !== 1'b0) begin
         miscompares++; $display("FAIL reset_ctrl: got ss_n=%b grant=%b busy=%b expected 11/00/0", ss_n, grant, busy);
      end
      vectors++;
      if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || core_wr !== 1'b0 || core_cs !== 1'b0) begin
         miscompares++; $display("FAIL reset_strobes: got ready=%b rspv=%b wr=%b cs=%b expected 0", req_ready, rsp_valid, core_wr, core_cs);
      end
      vectors++;
      if (rsp_data !== 8'h00 || core_din !== 8'h00) begin
         miscompares++; $display("FAIL reset_data: got rsp=%h din=%h expected 00", rsp_data, core_din);
      end
      rst = 1'b1; in_rst = 1'b0;
      tick();
   endtask

   task automatic test_round_robin();
      int n, run, seen;
      logic [NR-1:0] pg, order [4];
      key = 8'($urandom);
      for (int i = 0; i < 2; i++)
         for (int r = 0; r < NR; r++) txq[r].push_back('{8'($urandom), 1'b1, 0});
      n = 0; run = 0; seen = 0; pg = '0;
      for (int k = 0; k < 400 && n < 4; k++) begin
         tick();
         if (ss_n === 2'b11) run++;
         else begin
            if (run > 0 && seen > 0) begin
               vectors++;
               if (run < GAP) begin
                  miscompares++; $display("FAIL rr_gap: got %0d high cycles expected >= %0d", run, GAP);
               end
            end
            run = 0;
         end
         if (pg == '0 && grant != '0) begin
            order[n] = grant; n++; seen++;
         end
         pg = grant;
      end
      vectors++;
      if (n != 4) begin
         miscompares++; $display("FAIL rr_grant_count: got %0d expected 4", n);
      end else begin
         vectors++;
         if (order[0] !== 2'b01 || order[1] !== 2'b10 || order[2] !== 2'b01 || order[3] !== 2'b10) begin
            miscompares++; $display("FAIL rr_order: got %b %b %b %b expected 01 10 01 10", order[0], order[1], order[2], order[3]);
         end
      end
      wait_idle(200, "rr");
   endtask

   task automatic test_single();
      int lat, hi;
      logic ok;
      key = 8'h00;
      txq[0].push_back('{8'hA5, 1'b1, 0});
      lat = 0; ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         tick();
         if (req_ready[0]) begin ok = 1'b1; break; end
         lat++;
      end
      vectors++;
      if (!ok || lat != 1 + SETUP) begin
         miscompares++; $display("FAIL single_latency: got %0d expected %0d", lat, 1 + SETUP);
      end
      vectors++;
      if (ss_n !== 2'b10) begin
         miscompares++; $display("FAIL single_ss_n: got %b expected 10", ss_n);
      end
      ok = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (rsp_valid != '0) begin ok = 1'b1; break; end
         tick();
      end
      vectors++;
      if (!ok || rsp_valid !== 2'b01 || rsp_data !== 8'hA5) begin
         miscompares++; $display("FAIL single_rsp: got v=%b d=%h expected 01/a5", rsp_valid, rsp_data);
      end
      vectors++;
      if (ss_n !== 2'b11) begin
         miscompares++; $display("FAIL single_ss_release: got %b expected 11", ss_n);
      end
      hi = 0;
      for (int k = 0; k < 30 && busy; k++) begin
         if (ss_n === 2'b11) hi++;
         tick();
      end
      vectors++;
      if (hi != GAP || busy !== 1'b0) begin
         miscompares++; $display("FAIL single_gap: got %0d cycles busy=%b expected %0d/0", hi, busy, GAP);
      end
   endtask

   task automatic test_multi();
      int n_wr, n_rsp;
      logic ok;
      key = 8'($urandom);
      txq[0].push_back('{8'h01, 1'b0, 0});
      txq[0].push_back('{8'h02, 1'b0, 0});
      txq[0].push_back('{8'h03, 1'b1, 0});
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         tick();
         if (grant[0]) begin ok = 1'b1; break; end
      end
      vectors++;
      if (!ok) begin
         miscompares++; $display("FAIL multi_grant: got %b expected 01", grant);
      end
      n_wr = 0; n_rsp = 0;
      for (int k = 0; k < 200 && n_rsp < 3; k++) begin
         if (core_wr) n_wr++;
         if (rsp_valid[0]) n_rsp++;
         if (n_rsp < 3) begin
            vectors++;
            if (ss_n[0] !== 1'b0) begin
               miscompares++; $display("FAIL multi_ss_low: got %b expected 0", ss_n[0]);
            end
         end
         if (n_rsp < 3) tick();
      end
      vectors++;
      if (n_wr != 3 || n_rsp != 3) begin
         miscompares++; $display("FAIL multi_counts: got wr=%0d rsp=%0d expected 3/3", n_wr, n_rsp);
      end
      wait_idle(100, "multi");
   endtask

   task automatic test_stall();
      logic ok;
      key = 8'($urandom);
      txq[1].push_back('{8'($urandom), 1'b0, 0});
      txq[1].push_back('{8'($urandom), 1'b1, 25});
      txq[0].push_back('{8'($urandom), 1'b1, 3});
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (rsp_valid[1]) begin ok = 1'b1; break; end
      end
      vectors++;
      if (!ok) begin
         miscompares++; $display("FAIL stall_first_rsp: got %b expected 10", rsp_valid);
      end
      for (int k = 0; k < 8; k++) begin
         tick();
         vectors++;
         if (grant !== 2'b10 || ss_n !== 2'b01 || core_wr !== 1'b0 || req_ready !== 2'b00 || busy !== 1'b1) begin
            miscompares++; $display("FAIL stall_hold: got g=%b ss=%b wr=%b rdy=%b busy=%b expected 10/01/0/00/1",
                                    grant, ss_n, core_wr, req_ready, busy);
         end
      end
      wait_idle(300, "stall");
   endtask

   task automatic test_random();
      int nw, words, base;
      for (int rnd = 0; rnd < 6; rnd++) begin
         key = 8'($urandom);
         words = 0; base = rsp_total;
         for (int r = 0; r < NR; r++)
            for (int t = 0; t < int'($urandom_range(0, 2)); t++) begin
               nw = int'($urandom_range(1, 4));
               for (int w = 0; w < nw; w++) begin
                  txq[r].push_back('{8'($urandom), (w == nw - 1), int'($urandom_range(0, 3))});
                  words++;
               end
            end
         wait_idle(3000, "random");
         tick();
         vectors++;
         if (rsp_total - base != words) begin
            miscompares++; $display("FAIL random_rsp_count: got %0d expected %0d", rsp_total - base, words);
         end
      end
   endtask

   task automatic test_reset_mid();
      int cyc, g_cyc;
      logic ok, done_prev;
      key = 8'h3C; core_lat = 15;
      txq[0].push_back('{8'h5A, 1'b1, 0});
      ok = 1'b0;
      for (int k = 0; k < 60; k++) begin
         tick();
         if (core_done === 1'b0) begin ok = 1'b1; break; end
      end
      vectors++;
      if (!ok) begin
         miscompares++; $display("FAIL rstmid_core_start: got done=%b expected 0", core_done);
      end
      tick();
      rst = 1'b0; in_rst = 1'b1;
      #1;
      vectors++;
      if (ss_n !== 2'b11 || grant !== 2'b00 || busy !== 1'b0 || req_ready !== 2'b00) begin
         miscompares++; $display("FAIL rstmid_ctrl: got ss=%b g=%b busy=%b rdy=%b expected 11/00/0/00", ss_n, grant, busy, req_ready);
      end
      vectors++;
      if (rsp_valid !== 2'b00 || core_wr !== 1'b0 || rsp_data !== 8'h00 || core_din !== 8'h00) begin
         miscompares++; $display("FAIL rstmid_data: got v=%b wr=%b rsp=%h din=%h expected 0", rsp_valid, core_wr, rsp_data, core_din);
      end
      txq[1].push_back('{8'hC3, 1'b1, 0});
      tick();
      rst = 1'b1; in_rst = 1'b0;
      cyc = 0; g_cyc = -1; ok = 1'b0; done_prev = core_done;
      for (int k = 0; k < 200; k++) begin
         tick();
         cyc++;
         if (grant === 2'b10 && g_cyc < 0) g_cyc = cyc;
         if (req_ready[1]) begin ok = 1'b1; break; end
         done_prev = core_done;
      end
      vectors++;
      if (!ok || g_cyc < 0 || (cyc - g_cyc) < SETUP || done_prev !== 1'b1) begin
         miscompares++; $display("FAIL rstmid_ready: got ready=%b setup=%0d done_prev=%b expected >=%0d/1",
                                 ok, cyc - g_cyc, done_prev, SETUP);
      end
      wait_idle(200, "rstmid");
      core_lat = 5;
   endtask

   initial begin
      #1;
      test_reset();
      test_round_robin();
      test_single();
      test_multi();
      test_stall();
      test_random();
      test_reset_mid();
      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got no completion expected finish before %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
